// File: rtl/spi_csr_initiator_pkg.sv
// Shared types and constants for the SPI-to-CSR initiator.
package spi_csr_initiator_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StData,
    StRdAcc,
    StWrAcc
  } state_e;

  // Position of the read/write flag in the command byte (1 = write).
  localparam int unsigned RW_BIT = 7;

  // Metastability flops ahead of any use of an SPI pin.
  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronises one asynchronous pin into clk_i and flags its edges.
module spi_sync_edge
  import spi_csr_initiator_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge clk_i or negedge rstn_n) begin
    if (!rstn_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/spi_csr_initiator.sv
// SPI mode-0 target that turns host frames into CSR reads/writes, with burst auto-increment.
module spi_csr_initiator
  import spi_csr_initiator_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 7,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ACCESS_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_n,
  input  logic                  spi_sck_i,
  input  logic                  spi_cs_n_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  write_en_o,
  output logic                  read_en_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic                  busy_o,
  output logic                  frame_err_o
);

  localparam int unsigned CntW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  logic sck_level_unused, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk_i   (clk_i),
    .rstn_n  (rstn_n),
    .d_i     (spi_sck_i),
    .level_o (sck_level_unused),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk_i   (clk_i),
    .rstn_n  (rstn_n),
    .d_i     (spi_cs_n_i),
    .level_o (cs_level),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  // MOSI only needs its level; it is aligned with the synchronised SCK level.
  always_ff @(posedge clk_i or negedge rstn_n) begin
    if (!rstn_n) mosi_q <= '0;
    else         mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi_i};
  end
  assign mosi = mosi_q[SYNC_STAGES-1];

  // SCK activity while deselected is ignored.
  logic sck_rise_en, sck_fall_en;
  assign sck_rise_en = sck_rise & ~cs_level;
  assign sck_fall_en = sck_fall & ~cs_level;

  state_e                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d, tx_q, tx_d, wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CntW-1:0]       acc_cnt_q, acc_cnt_d;
  logic                  rw_q, rw_d, abort_q, abort_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  acc_last;

  assign rx_shift = {rx_q[DATA_WIDTH-2:0], mosi};
  assign acc_last = (acc_cnt_q == CntW'(ACCESS_CYCLES - 1));

  // Next-state logic: frame decode, shifting and strobe sequencing.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    acc_cnt_d = acc_cnt_q;
    rw_d      = rw_q;
    abort_d   = abort_q;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          bit_cnt_d = 3'd0;
          tx_d      = '0;
          abort_d   = 1'b0;
          state_d   = StCmd;
        end
      end
      StCmd: begin
        if (cs_rise) begin
          err_d   = (bit_cnt_q != 3'd0);
          state_d = StIdle;
        end else if (sck_rise_en) begin
          rx_d      = rx_shift;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_d    = rx_shift[ADDR_WIDTH-1:0];
            rw_d      = rx_shift[RW_BIT];
            acc_cnt_d = '0;
            state_d   = rx_shift[RW_BIT] ? StData : StRdAcc;
          end
        end
      end
      StData: begin
        if (cs_rise) begin
          err_d   = (bit_cnt_q != 3'd0);
          state_d = StIdle;
        end else begin
          // The fall right after a byte boundary must not shift: the freshly
          // loaded MSB has not been sampled by the host yet.
          if (sck_fall_en && bit_cnt_q != 3'd0) begin
            tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
          if (sck_rise_en) begin
            rx_d      = rx_shift;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              acc_cnt_d = '0;
              if (rw_q) begin
                wdata_d = rx_shift;
                state_d = StWrAcc;
              end else begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                state_d = StRdAcc;
              end
            end
          end
        end
      end
      StRdAcc: begin
        if (cs_rise) abort_d = 1'b1;
        acc_cnt_d = acc_cnt_q + CntW'(1);
        if (acc_last) begin
          tx_d      = read_data_i;
          acc_cnt_d = '0;
          state_d   = (abort_q || cs_rise) ? StIdle : StData;
        end
      end
      StWrAcc: begin
        if (cs_rise) abort_d = 1'b1;
        acc_cnt_d = acc_cnt_q + CntW'(1);
        if (acc_last) begin
          acc_cnt_d = '0;
          if (abort_q || cs_rise) begin
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = StData;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rstn_n) begin
    if (!rstn_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      acc_cnt_q <= '0;
      rw_q      <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      acc_cnt_q <= acc_cnt_d;
      rw_q      <= rw_d;
      abort_q   <= abort_d;
      err_q     <= err_d;
    end
  end

  assign addr_o        = addr_q;
  assign write_data_o  = wdata_q;
  assign write_en_o    = (state_q == StWrAcc);
  assign read_en_o     = (state_q == StRdAcc);
  assign busy_o        = (state_q != StIdle);
  assign frame_err_o   = err_q;
  assign spi_miso_oe_o = ~cs_level;
  assign spi_miso_o    = ~cs_level & tx_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_csr_initiator.sv
// Scoreboard bench: SPI host stimulus, CSR register-map model, strobe monitor.
module tb_spi_csr_initiator;

  localparam int HALF = 12;  // clk cycles per SCK phase

  logic       clk = 1'b0;
  logic       rstn_n = 1'b0;
  logic       sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       miso, oe, wen, ren, busy, ferr;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;

  logic [7:0] csr_mem   [128];  // register map seen by the DUT
  logic [7:0] model_mem [128];  // reference view of the same map

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wr_exp[$];
  logic [6:0] rd_exp[$];
  logic [7:0] miso_obs[$];
  logic [7:0] fb[$];

  int tests = 0, fails = 0, err_seen = 0;
  bit ignore_strobes = 1'b0;

  spi_csr_initiator dut (
    .clk_i         (clk),
    .rstn_n        (rstn_n),
    .spi_sck_i     (sck),
    .spi_cs_n_i    (cs_n),
    .spi_mosi_i    (mosi),
    .spi_miso_o    (miso),
    .spi_miso_oe_o (oe),
    .addr_o        (addr),
    .write_data_o  (wdata),
    .write_en_o    (wen),
    .read_en_o     (ren),
    .read_data_i   (rdata),
    .busy_o        (busy),
    .frame_err_o   (ferr)
  );

  always #5 clk = ~clk;

  assign rdata = csr_mem[addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: strobe seen, none expected", name);
  endtask

  // Monitor: pops expected accesses as strobes appear and checks them.
  logic       wr_prev = 1'b0, rd_prev = 1'b0;
  int         wr_len = 0, rd_len = 0;
  logic [6:0] s_addr, r_addr;
  logic [7:0] s_data;
  wr_t        e;
  logic [6:0] ea;

  always @(negedge clk) begin
    if (!rstn_n || ignore_strobes) begin
      wr_prev = 1'b0; rd_prev = 1'b0; wr_len = 0; rd_len = 0;
    end else begin
      if (ferr) err_seen++;
      if (wen && ren) check("strobes exclusive", {wen, ren}, 2'b00);
      if (wen) begin
        if (!wr_prev) begin
          wr_len = 0; s_addr = addr; s_data = wdata;
          if (wr_exp.size() == 0) fail_now("unexpected write");
          else begin
            e = wr_exp.pop_front();
            check("write addr", addr, e.a);
            check("write data", wdata, e.d);
          end
        end else begin
          check("write addr stable", addr, s_addr);
          check("write data stable", wdata, s_data);
        end
        wr_len++;
      end else if (wr_prev) begin
        check("write strobe length", wr_len, 4);
        csr_mem[s_addr] = s_data;
      end
      if (ren) begin
        if (!rd_prev) begin
          rd_len = 0; r_addr = addr;
          if (rd_exp.size() == 0) fail_now("unexpected read");
          else begin
            ea = rd_exp.pop_front();
            check("read addr", addr, ea);
          end
        end else check("read addr stable", addr, r_addr);
        rd_len++;
      end else if (rd_prev) begin
        check("read strobe length", rd_len, 4);
      end
      wr_prev = wen;
      rd_prev = ren;
    end
  end

  task automatic half();
    repeat (HALF) @(posedge clk);
    #2;
  endtask

  // Shifts nbits of b MSB-first; got collects MISO as sampled at each rising SCK.
  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      half();
      got = {got[6:0], miso};
      sck = 1'b1;
      half();
      sck = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy drops", busy, 0);
  endtask

  // Builds expectations from the frame in fb, drives it, then checks the frame outcome.
  task automatic run(input int last_bits);
    logic [7:0] cmd, got;
    logic [6:0] a;
    logic [7:0] exp_miso[$];
    int nfull, errs0;
    wr_t w;
    cmd = fb[0];
    a = cmd[6:0];
    nfull = (last_bits == 8) ? fb.size() - 1 : fb.size() - 2;
    for (int i = 0; i < nfull; i++) begin
      if (cmd[7]) begin
        w.a = a + 7'(i); w.d = fb[i+1];
        wr_exp.push_back(w);
        model_mem[a + 7'(i)] = fb[i+1];
      end else begin
        rd_exp.push_back(a + 7'(i));
        exp_miso.push_back(model_mem[a + 7'(i)]);
      end
    end
    if (!cmd[7]) rd_exp.push_back(a + 7'(nfull));  // prefetch after the last full byte
    errs0 = err_seen;
    miso_obs.delete();
    cs_n = 1'b0;
    half();
    check("miso_oe selected", oe, 1);
    for (int b = 0; b < fb.size(); b++) begin
      xfer(fb[b], (b == fb.size() - 1) ? last_bits : 8, got);
      miso_obs.push_back(got);
    end
    half();
    cs_n = 1'b1;
    half();
    wait_idle();
    repeat (4) @(negedge clk);
    check("frame_err count", err_seen - errs0, (last_bits != 8) ? 1 : 0);
    check("writes drained", wr_exp.size(), 0);
    check("reads drained", rd_exp.size(), 0);
    check("cmd byte miso", miso_obs[0], 0);
    for (int i = 0; i < exp_miso.size(); i++) check("miso data byte", miso_obs[i+1], exp_miso[i]);
    check("miso_oe released", oe, 0);
    wr_exp.delete();
    rd_exp.delete();
  endtask

  task automatic check_all_zero();
    check("rst addr", addr, 0);
    check("rst wdata", wdata, 0);
    check("rst write_en", wen, 0);
    check("rst read_en", ren, 0);
    check("rst busy", busy, 0);
    check("rst frame_err", ferr, 0);
    check("rst miso", miso, 0);
    check("rst miso_oe", oe, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got, v;
    int n, errs0, len;
    wr_t w;
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom);
      csr_mem[i] = v;
      model_mem[i] = v;
    end
    repeat (3) @(posedge clk);
    #1 check_all_zero();
    @(posedge clk); #2 rstn_n = 1'b1;
    repeat (5) @(posedge clk);

    // Single write.
    fb.delete(); fb.push_back(8'h85); fb.push_back(8'h3C);
    run(8);

    // Single read with prefetch of the next address.
    csr_mem[5] = 8'hA7; model_mem[5] = 8'hA7;
    fb.delete(); fb.push_back(8'h05); fb.push_back(8'h00);
    run(8);

    // Burst write across the address wrap.
    fb.delete();
    fb.push_back(8'hFE); fb.push_back(8'h11); fb.push_back(8'h22); fb.push_back(8'h33);
    run(8);

    // Partial data byte abort.
    fb.delete(); fb.push_back(8'h90); fb.push_back(8'hAB);
    run(3);

    // Deselect while a write strobe is active: strobe must complete.
    w.a = 7'h0A; w.d = 8'h5A;
    wr_exp.push_back(w);
    model_mem[7'h0A] = 8'h5A;
    errs0 = err_seen;
    cs_n = 1'b0;
    half();
    xfer(8'h8A, 8, got);
    xfer(8'h5A, 7, got);
    mosi = 1'b0;
    half();
    sck = 1'b1;
    n = 0;
    while (!wen && n < 30) begin @(negedge clk); n++; end
    check("write strobe seen", wen, 1);
    #2 cs_n = 1'b1;
    half();
    sck = 1'b0;
    half();
    wait_idle();
    repeat (4) @(negedge clk);
    check("no error on access deselect", err_seen - errs0, 0);
    check("deselect write drained", wr_exp.size(), 0);
    wr_exp.delete();

    // Asynchronous reset in the middle of a read strobe.
    cs_n = 1'b0;
    half();
    xfer(8'h05, 7, got);
    mosi = 1'b1;
    half();
    sck = 1'b1;
    ignore_strobes = 1'b1;
    n = 0;
    while (!ren && n < 30) begin @(negedge clk); n++; end
    check("read strobe seen", ren, 1);
    #3 rstn_n = 1'b0;
    #1 check_all_zero();
    sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn_n = 1'b1;
    ignore_strobes = 1'b0;
    repeat (5) @(posedge clk);
    fb.delete(); fb.push_back(8'h85); fb.push_back(8'h3C);
    run(8);

    // Randomised frames against the register-map model.
    for (int f = 0; f < 20; f++) begin
      fb.delete();
      fb.push_back(8'($urandom));
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
      if ($urandom_range(0, 5) == 0) run($urandom_range(1, 7));
      else run(8);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_csr_initiator.md
Name: spi_csr_initiator

Overview:
- SPI target front-end that turns serial frames from an external host into parallel accesses on the CSR interface (addr/write_data/write_en/read_en/read_data) of the chip's register map.
- Sits between the chip pads and the register map; the single bus initiator on that interface.
- Supports single and burst (auto-increment) reads/writes.

Parameters:
- ADDR_WIDTH, 7, CSR address width; command byte = {rw, addr[6:0]}.
- DATA_WIDTH, 8, CSR data width; one SPI data byte per access.
- ACCESS_CYCLES, 4, consecutive clk_i cycles each write_en_o/read_en_o strobe is held; must be >= 3.

Ports:
- clk_i  in  1  system clock.
- rstn_n  in  1  asynchronous active-low reset.
- spi_sck_i  in  1  SPI clock, mode 0, asynchronous to clk_i.
- spi_cs_n_i  in  1  SPI chip select, active-low.
- spi_mosi_i  in  1  host-to-target data, MSB first.
- spi_miso_o  out  1  target-to-host data, MSB first.
- spi_miso_oe_o  out  1  pad output enable for MISO.
- addr_o  out  ADDR_WIDTH  CSR address.
- write_data_o  out  DATA_WIDTH  CSR write data.
- write_en_o  out  1  CSR write strobe.
- read_en_o  out  1  CSR read strobe.
- read_data_i  in  DATA_WIDTH  CSR read data.
- busy_o  out  1  high in any state except IDLE.
- frame_err_o  out  1  one-cycle pulse on a partial-byte frame abort.

Behaviour:
- Reset (async assert, sync-to-clk deassert is external):
  - All outputs are 0; spi_miso_o = 0; state = IDLE.
  - Synchronizer flops reset to sck = 0, cs_n = 1, mosi = 0.
- Input sync: sck, cs_n and mosi each pass through 2 flops, plus 1 history flop on sck and cs_n for edge detect.
  - sck_rise, sck_fall, cs_fall and cs_rise are 1-cycle pulses, 3 cycles after the pin edge.
- Frame format:
  - byte0 = {rw, addr}; rw = 1 is a write.
  - Following bytes are data.
  - MOSI is sampled on sck_rise; MISO is updated on sck_fall; MSB first.
- MISO drive:
  - spi_miso_oe_o = ~cs_n_sync.
  - spi_miso_o = tx_shift MSB while selected, else 0.
  - tx_shift is 0 during byte0.
- Timing requirement on the host: SCK high and low phases each >= ACCESS_CYCLES + 5 clk_i cycles.
- FSM:
  - IDLE: addr_o, write_data_o and strobes hold. On cs_fall: bit_cnt = 0, go to CMD.
  - CMD: shift rx on sck_rise, bit_cnt++. On 8th bit: latch addr_o = rx[6:0] and rw; bit_cnt = 0. rw = 0 goes to RD_ACC; rw = 1 goes to DATA.
  - RD_ACC:
    - read_en_o = 1 for exactly ACCESS_CYCLES cycles with addr_o stable.
    - On the last cycle, tx_shift = read_data_i.
    - Then go to DATA.
  - DATA: rx shifts on sck_rise; tx shifts on sck_fall. On 8th bit, bit_cnt = 0, then:
    - write: write_data_o = rx; go to WR_ACC.
    - read: addr_o = addr_o + 1; go to RD_ACC (prefetch).
  - WR_ACC:
    - write_en_o = 1 for exactly ACCESS_CYCLES cycles; addr_o and write_data_o stable throughout.
    - Then addr_o = addr_o + 1; go to DATA.
- Address increment wraps modulo 2^ADDR_WIDTH (0x7F -> 0x00).
- write_en_o and read_en_o are never high simultaneously.
- cs_rise handling:
  - In CMD or DATA with bit_cnt != 0: frame_err_o pulses; no access; go to IDLE.
  - In CMD or DATA with bit_cnt == 0: clean end; go to IDLE.
  - In RD_ACC or WR_ACC: finish the current strobe to its full length, then go to IDLE. Strobes are never truncated.
- cs_fall while not IDLE is impossible after a prior cs_rise; a new cs_fall is accepted only in IDLE.
- Prefetch read after a burst's last byte is harmless and is issued.
- sck edges while cs_n_sync = 1 are ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, CMD, DATA, RD_ACC, WR_ACC.
  - RW_BIT = 7.
  - SYNC_STAGES = 2.
- One sub-module: spi_sync_edge.
  - Parameter: reset value.
  - Does 2-flop sync plus history flop.
  - Outputs: level, rise, fall.
  - Instantiated for sck and cs_n; mosi uses level only.
- Top holds the FSM, shift registers, bit_cnt, strobe counter, and addr/data registers.

Test Plan:
- Single write: frame 0x85, 0x3C.
  -> write_en_o high 4 cycles with addr_o = 0x05, write_data_o = 0x3C.
  -> read_en_o never high; frame_err_o stays 0.
- Single read: frame 0x05, 0x00 with read_data_i = 0xA7 for addr 0x05.
  -> read_en_o high 4 cycles at addr 0x05.
  -> MISO shifts out 10100111 in byte1.
  -> A second read_en burst at addr 0x06 follows.
- Burst write wrap: frame 0xFE, 0x11, 0x22, 0x33.
  -> writes (0x7E, 0x11), (0x7F, 0x22), (0x00, 0x33), in order, each strobe 4 cycles.
- Abort: cs_n rises after 3 bits of the data byte in a write frame.
  -> frame_err_o pulses once; no write_en_o; busy_o drops to 0.
- cs_n rises during WR_ACC cycle 2 -> write_en_o still high the full 4 cycles, then IDLE, no error pulse.
- Async reset asserted mid-RD_ACC -> all outputs 0 immediately; the next frame 0x85, 0x3C behaves as the single-write scenario.
